// File: rtl/tx_byte_queue.sv
// ---------------------------------------------------------------------------
// tx_byte_queue
//
// Byte FIFO that sits in front of a uart_tx transmitter. Producers push
// bytes with a write strobe. A small launcher FSM pops the head byte whenever
// the transmitter is idle, then hands it over with a one-cycle i_Tx_DV pulse.
// It then waits for the transmitter's o_Tx_Done before it looks at the queue
// again.
//
// Parameters
//   DEPTH : queue capacity in bytes (power of two, 2..256)
//   CW    : count width, log2(DEPTH)+1
//
// Ports
//   i_Clock     : single clock, rising edge
//   i_Reset     : synchronous active-high reset
//   i_Wr_DV     : write strobe, one byte per high cycle
//   i_Wr_Byte   : write data
//   o_Full      : count == DEPTH (registered)
//   o_Empty     : count == 0 (registered)
//   o_Count     : number of stored bytes (registered)
//   o_Overflow  : sticky, set when a write is dropped because the queue is full
//   o_Tx_DV     : one-cycle launch pulse to uart_tx
//   o_Tx_Byte   : byte presented to uart_tx, held from one pop to the next
//   i_Tx_Active : uart_tx busy indication
//   i_Tx_Done   : uart_tx end-of-frame pulse
// ---------------------------------------------------------------------------
module tx_byte_queue #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    input  logic          i_Wr_DV,
    input  logic [7:0]    i_Wr_Byte,
    output logic          o_Full,
    output logic          o_Empty,
    output logic [CW-1:0] o_Count,
    output logic          o_Overflow,
    output logic          o_Tx_DV,
    output logic [7:0]    o_Tx_Byte,
    input  logic          i_Tx_Active,
    input  logic          i_Tx_Done
);

    localparam int            AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Storage: plain array, no reset, so it maps onto block/distributed RAM.
    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          full_reg;
    logic          empty_reg;
    logic          overflow_reg;
    logic [7:0]    tx_byte_reg;
    logic          tx_dv;
    state_t        state_reg;
    state_t        state_next;

    logic          wr_accept;
    logic          wr_drop;
    logic          pop;

    // Full/empty decisions use the registered flags only. A byte written
    // into an empty queue therefore cannot be popped in the same cycle. A
    // write seen while full is dropped even if a pop frees a slot that cycle.
    assign wr_accept = i_Wr_DV & ~full_reg;
    assign wr_drop   = i_Wr_DV &  full_reg;
    assign pop       = (state_reg == IDLE) & ~empty_reg & ~i_Tx_Active;

    always_comb begin
        count_next = count_reg;
        case ({wr_accept, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;   // idle, or write+pop cancel out
        endcase
    end

    // RAM write port. Reset only has to stop the pointers moving, but a
    // write is also suppressed during reset so nothing lands in the array.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset && wr_accept) begin
            mem[wr_ptr_reg] <= i_Wr_Byte;
        end
    end

    // Pointers, occupancy flags and the registered read into o_Tx_Byte.
    // A pop never reads the slot being written in the same cycle. A pop
    // needs a non-empty queue, and a write needs a non-full one, so the two
    // pointers differ whenever both happen.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            tx_byte_reg  <= 8'h00;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);   // power-of-two depth wraps naturally
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                tx_byte_reg <= mem[rd_ptr_reg];
            end
            if (wr_drop) begin
                overflow_reg <= 1'b1;                // sticky until reset
            end
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_C);
            empty_reg <= (count_next == '0);
        end
    end

    // Launcher FSM: state register.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Launcher FSM: next state. i_Tx_Done only matters in WAIT_DONE. Going
    // back through IDLE before the next LAUNCH gives uart_tx a cycle to
    // settle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (pop) state_next = LAUNCH;
            LAUNCH:    state_next = WAIT_DONE;
            WAIT_DONE: if (i_Tx_Done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Launcher FSM: outputs. The state register drives the pulse, so it
    // carries no combinational path from the inputs.
    always_comb begin
        tx_dv = 1'b0;
        if (state_reg == LAUNCH) begin
            tx_dv = 1'b1;
        end
    end

    assign o_Full     = full_reg;
    assign o_Empty    = empty_reg;
    assign o_Count    = count_reg;
    assign o_Overflow = overflow_reg;
    assign o_Tx_DV    = tx_dv;
    assign o_Tx_Byte  = tx_byte_reg;

endmodule

// File: tb/tb_tx_byte_queue.sv
module tb_tx_byte_queue;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_dv;
    logic [7:0]    wr_byte;
    logic          tx_active;
    logic          tx_done;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;
    logic          tx_dv;
    logic [7:0]    tx_byte;

    always #5 clk = ~clk;

    tx_byte_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (ovf),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done)
    );

    int tests = 0;
    int fails = 0;

    // uart_tx stand-in: busy for uart_cyc edges after a launch, then Done.
    bit uart_en  = 0;
    int uart_cnt = 0;
    int uart_cyc = 20;   // 10 bit times at CLKS_PER_BIT=2

    // Reference model: the queue as an SV queue, plus whether a byte is
    // "out at the transmitter" (busy) and whether the launch pulse is due.
    logic [7:0] mq[$];
    bit         m_ovf    = 0;
    bit         m_busy   = 0;
    bit         m_launch = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         model_chk = 0;

    logic [7:0] launched[$];

    typedef struct {
        bit         rst;
        bit         wr;
        logic [7:0] b;
        bit         act;
        bit         done;
        int         cnt;
        bit         emp;
        bit         ful;
        bit         ovf;
        bit         dv;
        logic [7:0] tb;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit w, input logic [7:0] b,
                              input bit a, input bit d);
        int  pre_size;
        bit  do_pop;
        if (r) begin
            mq.delete();
            m_ovf    = 0;
            m_busy   = 0;
            m_launch = 0;
            m_byte   = 8'h00;
        end else begin
            pre_size = mq.size();
            do_pop   = !m_busy && pre_size > 0 && !a;
            // A byte is handed back only once the launch pulse is over.
            if (m_busy && !m_launch && d) m_busy = 0;
            m_launch = do_pop;
            if (do_pop) begin
                m_byte = mq.pop_front();
                m_busy = 1;
            end
            if (w) begin
                if (pre_size < DEPTH) mq.push_back(b);
                else                  m_ovf = 1;
            end
        end
    endtask

    task automatic tick();
        logic       dv_pre, r_p, w_p, a_p, d_p;
        logic [7:0] b_p;
        dv_pre = tx_dv;
        r_p = rst; w_p = wr_dv; b_p = wr_byte; a_p = tx_active; d_p = tx_done;
        @(posedge clk);
        #1;
        model_step(r_p, w_p, b_p, a_p, d_p);
        if (uart_en) begin
            tx_done = 1'b0;
            if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    tx_active = 1'b0;
                    tx_done   = 1'b1;
                end
            end else if (dv_pre === 1'b1) begin
                tx_active = 1'b1;
                uart_cnt  = uart_cyc;
            end
        end
        if (tx_dv === 1'b1) launched.push_back(tx_byte);
        if (model_chk) begin
            tests++;
            if (count !== CW'(mq.size()) || empty !== (mq.size() == 0) ||
                full !== (mq.size() == DEPTH) || ovf !== m_ovf ||
                tx_dv !== m_launch || tx_byte !== m_byte) begin
                fails++;
                $display("FAIL model t=%0t count %0d/%0d empty %b/%b full %b/%b ovf %b/%b dv %b/%b byte %h/%h",
                         $time, count, mq.size(), empty, (mq.size() == 0), full, (mq.size() == DEPTH),
                         ovf, m_ovf, tx_dv, m_launch, tx_byte, m_byte);
            end
        end
    endtask

    task automatic reset_all();
        uart_cnt  = 0;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        rst = 1'b1; wr_dv = 1'b0;
        tick();
        rst = 1'b0;
        launched.delete();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_dv = 1'b1; wr_byte = b;
        tick();
        wr_dv = 1'b0;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((mq.size() > 0 || m_busy || tx_active) && n < max) begin
            tick();
            n++;
        end
        tick();
        check("drain_within_budget", (n < max), 1);
    endtask

    task automatic check_launch_seq(input string name, input logic [7:0] first, input int len);
        check({name, "_count"}, launched.size(), len);
        for (int i = 0; i < launched.size() && i < len; i++) begin
            check({name, "_order"}, launched[i], 32'(first) + 32'(i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_dv = 1'b0; wr_byte = 8'h00; tx_active = 1'b0; tx_done = 1'b0;

        //          rst wr  byte   act done  cnt emp ful ovf dv  tx_byte
        vt[0]  = '{1, 0, 8'h00, 0, 0,   0, 1, 0, 0, 0, 8'h00};
        vt[1]  = '{0, 1, 8'h55, 0, 0,   1, 0, 0, 0, 0, 8'h00};  // no pop on write cycle
        vt[2]  = '{0, 0, 8'h00, 0, 0,   0, 1, 0, 0, 1, 8'h55};  // pop, LAUNCH
        vt[3]  = '{0, 0, 8'h00, 1, 0,   0, 1, 0, 0, 0, 8'h55};  // WAIT_DONE
        vt[4]  = '{0, 1, 8'hA1, 1, 0,   1, 0, 0, 0, 0, 8'h55};
        vt[5]  = '{0, 1, 8'hA2, 0, 1,   2, 0, 0, 0, 0, 8'h55};  // done -> IDLE
        vt[6]  = '{0, 0, 8'h00, 0, 0,   1, 0, 0, 0, 1, 8'hA1};  // relaunch
        vt[7]  = '{0, 0, 8'h00, 0, 1,   1, 0, 0, 0, 0, 8'hA1};  // done in LAUNCH ignored
        vt[8]  = '{0, 0, 8'h00, 0, 0,   1, 0, 0, 0, 0, 8'hA1};  // still waiting
        vt[9]  = '{0, 0, 8'h00, 0, 1,   1, 0, 0, 0, 0, 8'hA1};  // -> IDLE
        vt[10] = '{0, 0, 8'h00, 1, 0,   1, 0, 0, 0, 0, 8'hA1};  // active blocks pop
        vt[11] = '{0, 0, 8'h00, 0, 0,   0, 1, 0, 0, 1, 8'hA2};
        vt[12] = '{1, 1, 8'h77, 0, 0,   0, 1, 0, 0, 0, 8'h00};  // reset wins

        for (int i = 0; i < 13; i++) begin
            rst = vt[i].rst; wr_dv = vt[i].wr; wr_byte = vt[i].b;
            tx_active = vt[i].act; tx_done = vt[i].done;
            tick();
            $display("[TB] vec %0d: count=%0d empty=%b full=%b ovf=%b dv=%b byte=%h",
                     i, count, empty, full, ovf, tx_dv, tx_byte);
            tests++;
            if (count !== CW'(vt[i].cnt) || empty !== vt[i].emp || full !== vt[i].ful ||
                ovf !== vt[i].ovf || tx_dv !== vt[i].dv || tx_byte !== vt[i].tb) begin
                fails++;
                $display("FAIL vec%0d: got cnt=%0d emp=%b ful=%b ovf=%b dv=%b byte=%h expected cnt=%0d emp=%b ful=%b ovf=%b dv=%b byte=%h",
                         i, count, empty, full, ovf, tx_dv, tx_byte,
                         vt[i].cnt, vt[i].emp, vt[i].ful, vt[i].ovf, vt[i].dv, vt[i].tb);
            end
        end
        rst = 1'b0; wr_dv = 1'b0; tx_active = 1'b0; tx_done = 1'b0;

        model_chk = 1;
        uart_en   = 1;

        // Single byte: launch two cycles after the write edge.
        reset_all();
        write_byte(8'h55);
        check("single_dv_after_write", tx_dv, 0);
        check("single_not_empty", empty, 0);
        tick();
        check("single_dv_pulse", tx_dv, 1);
        check("single_byte", tx_byte, 8'h55);
        check("single_empty_after_pop", empty, 1);
        tick();
        check("single_dv_one_cycle", tx_dv, 0);
        drain(200);
        $display("[TB] single byte sequence done, %0d launches", launched.size());

        // Ordering through the uart model.
        reset_all();
        write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
        drain(400);
        check_launch_seq("order", 8'h01, 3);
        $display("[TB] ordering sequence done, %0d launches", launched.size());

        // Full and overflow with the transmitter held busy.
        reset_all();
        uart_en = 0; tx_active = 1'b1;
        for (int i = 0; i < 17; i++) write_byte(8'h10 + 8'(i));
        check("full_count", count, DEPTH);
        check("full_flag", full, 1);
        check("overflow_set", ovf, 1);
        tick();
        check("overflow_sticky", ovf, 1);
        tx_active = 1'b0; uart_en = 1;
        drain(1000);
        check_launch_seq("full_order", 8'h10, 16);
        check("overflow_after_drain", ovf, 1);
        $display("[TB] full/overflow sequence done, %0d launches", launched.size());

        // Wrap-around: 40 bytes in bursts of 10.
        reset_all();
        for (int burst = 0; burst < 4; burst++) begin
            for (int k = 0; k < 10; k++) write_byte(8'(burst * 10 + k));
            drain(1000);
        end
        check_launch_seq("wrap", 8'h00, 40);
        $display("[TB] wrap-around sequence done, %0d launches", launched.size());

        // Simultaneous write and pop at count 5.
        reset_all();
        uart_en = 0; tx_active = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'h30 + 8'(i));
        check("simul_pre_count", count, 5);
        tx_active = 1'b0; wr_dv = 1'b1; wr_byte = 8'h35;
        tick();
        wr_dv = 1'b0; uart_en = 1;
        check("simul_count_kept", count, 5);
        check("simul_dv", tx_dv, 1);
        check("simul_byte", tx_byte, 8'h30);
        drain(1000);
        check_launch_seq("simul_order", 8'h30, 6);
        $display("[TB] simultaneous write/pop sequence done, %0d launches", launched.size());

        // Reset while waiting for Done with 4 bytes queued; uart keeps running.
        reset_all();
        for (int i = 0; i < 5; i++) write_byte(8'h40 + 8'(i));
        check("rst_pre_count", count, 4);
        check("rst_pre_active", tx_active, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_dv", tx_dv, 0);
        check("rst_ovf", ovf, 0);
        launched.delete();
        for (int i = 0; i < 80; i++) tick();
        check("rst_no_launch", launched.size(), 0);
        $display("[TB] mid-operation reset sequence done");

        // Randomized traffic against the model.
        reset_all();
        for (int phase = 0; phase < 6; phase++) begin
            int rate;
            rate = (phase % 3 == 0) ? 10 : ((phase % 3 == 1) ? 45 : 95);
            for (int c = 0; c < 600; c++) begin
                if (uart_cnt == 0) uart_cyc = int'($urandom_range(1, 12));
                wr_dv   = ($urandom_range(0, 99) < rate);
                wr_byte = 8'($urandom);
                rst     = ($urandom_range(0, 799) == 0);
                tick();
            end
            rst = 1'b0; wr_dv = 1'b0;
            $display("[TB] random phase %0d (rate %0d%%) done, %0d launches so far",
                     phase, rate, launched.size());
        end
        drain(2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
